game_sequencer: RTL and testbench

- Top-level game controller for the 8x8 LED-matrix Flappy Bird.
- Owns the play/crash/game-over sequence and generates the reset for the pipe/bird datapath.
- Paces pipe scrolling with a one-cycle shift-enable pulse whose period shortens as score rises.
- Detects collisions, keeps the BCD score and high score.
- Runs on the divided game clock, alongside the pipe shift chain, bird, score HEX decoders and LED matrix driver.

---
 rtl/game_sequencer_if.sv | 27 ++
 rtl/game_sequencer.sv | 141 ++++++++++++++
 tb/tb_game_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Signal bundle between the Flappy Bird game sequencer and the rest of the game.
// The master side is the sequencer; the slave side is the datapath/display.
interface game_sequencer_if;
   logic            start;
   logic [7:0][7:0] red;
   logic [7:0][7:0] green;
   logic            bird_lose;
   logic            game_reset;
   logic            scroll_en;
   logic            freeze;
   logic            blank;
   logic [11:0]     score_bcd;
   logic [11:0]     hi_bcd;
   logic [1:0]      state;

   modport master (
      input  start, red, green, bird_lose,
      output game_reset, scroll_en, freeze, blank,
      output score_bcd, hi_bcd, state
   );

   modport slave (
      output start, red, green, bird_lose,
      input  game_reset, scroll_en, freeze, blank,
      input  score_bcd, hi_bcd, state
   );
endinterface

// File: rtl/game_sequencer.sv
// Flappy Bird game controller: play/crash/over sequencing, scroll pacing,
// collision detection and BCD score / high-score keeping.
module game_sequencer #(
   parameter int SCROLL_START  = 8,
   parameter int SCROLL_MIN    = 2,
   parameter int SPEEDUP_EVERY = 5,
   parameter int CRASH_TICKS   = 16
) (
   input logic              clk,
   input logic              reset,
   game_sequencer_if.master gs
);

   localparam int CW = $clog2(CRASH_TICKS);
   localparam int PW = $clog2(SPEEDUP_EVERY + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      CRASH = 2'd2,
      OVER  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [11:0]     score_q, score_d;
   logic [11:0]     hi_q, hi_d;
   logic [3:0]      period_q, period_d;
   logic [3:0]      scnt_q, scnt_d;
   logic [CW-1:0]   ccnt_q, ccnt_d;
   logic [PW-1:0]   pstep_q, pstep_d;
   logic            collide;
   logic            hit;
   logic            wrap;
   logic            award;

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v != 12'h999) begin
         if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
         end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
               r[7:4] = v[7:4] + 4'd1;
            end else begin
               r[7:4]  = 4'd0;
               r[11:8] = v[11:8] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      hi_d     = hi_q;
      period_d = period_q;
      scnt_d   = scnt_q;
      ccnt_d   = ccnt_q;
      pstep_d  = pstep_q;

      collide = |(gs.red & gs.green);
      hit     = collide | gs.bird_lose;
      wrap    = (state_q == PLAY) && (scnt_q == period_q - 4'd1);
      award   = wrap && !hit && (gs.green[0] != 8'd0);

      unique case (state_q)
         IDLE: begin
            if (gs.start) begin
               state_d  = PLAY;
               score_d  = 12'h000;
               period_d = 4'(SCROLL_START);
               scnt_d   = 4'd0;
               pstep_d  = '0;
            end
         end
         PLAY: begin
            if (hit) begin
               state_d = CRASH;
               ccnt_d  = '0;
            end else begin
               scnt_d = wrap ? 4'd0 : scnt_q + 4'd1;
               if (award) begin
                  score_d = bcd_inc(score_q);
                  if (pstep_q == PW'(SPEEDUP_EVERY - 1)) begin
                     pstep_d = '0;
                     if (period_q > 4'(SCROLL_MIN))
                        period_d = period_q - 4'd1;
                  end else begin
                     pstep_d = pstep_q + 1'b1;
                  end
               end
            end
         end
         CRASH: begin
            ccnt_d = ccnt_q + 1'b1;
            if (ccnt_q == CW'(CRASH_TICKS - 1)) begin
               state_d = OVER;
               // Valid BCD orders the same as binary, MSD first
               if (score_q > hi_q)
                  hi_d = score_q;
            end
         end
         OVER: begin
            if (gs.start)
               state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         score_q  <= 12'h000;
         hi_q     <= 12'h000;
         period_q <= 4'(SCROLL_START);
         scnt_q   <= 4'd0;
         ccnt_q   <= '0;
         pstep_q  <= '0;
      end else begin
         state_q  <= state_d;
         score_q  <= score_d;
         hi_q     <= hi_d;
         period_q <= period_d;
         scnt_q   <= scnt_d;
         ccnt_q   <= ccnt_d;
         pstep_q  <= pstep_d;
      end
   end

   assign gs.scroll_en  = wrap && !hit;
   assign gs.game_reset = (state_q == IDLE);
   assign gs.freeze     = (state_q != PLAY);
   assign gs.blank      = (state_q == CRASH) && ccnt_q[1];
   assign gs.score_bcd  = score_q;
   assign gs.hi_bcd     = hi_q;
   assign gs.state      = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer: idle, scroll pacing,
// speed-up, BCD scoring, crash flash, high score and mid-crash reset.
module tb_game_sequencer;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   game_sequencer_if gs();

   game_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .gs    (gs)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic wait_pulse(output int n);
      n = 0;
      while (!gs.scroll_en && n < 64) begin
         tick;
         n++;
      end
      chk("pulse_seen", 32'(gs.scroll_en), 32'd1);
      n++;
      tick;
   endtask

   // Interval for point p follows max(MIN, START - (p-1)/EVERY)
   task automatic play_points(input int from, input int upto);
      int n;
      int per;
      int pts;
      for (int p = from; p <= upto; p++) begin
         wait_pulse(n);
         per = 8 - (p - 1) / 5;
         if (per < 2) per = 2;
         chk("interval", n, per);
         pts = (p > 999) ? 999 : p;
         chk("score", 32'(gs.score_bcd), 32'(to_bcd(pts)));
      end
   endtask

   task automatic crash_flash(input bit poke_start);
      logic [15:0] bm;
      bm = '0;
      for (int i = 0; i < 16; i++) begin
         bm[i] = gs.blank;
         chk("crash_freeze", 32'(gs.freeze), 32'd1);
         chk("crash_se", 32'(gs.scroll_en), 32'd0);
         gs.start = poke_start && (i == 4);
         tick;
      end
      gs.start = 1'b0;
      chk("blank_pattern", 32'(bm), 32'h0000cccc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bit seen;
      reset        = 1'b1;
      gs.start     = 1'b0;
      gs.red       = '0;
      gs.green     = '0;
      gs.bird_lose = 1'b0;
      tick;
      tick;
      reset = 1'b0;
      chk("rst_state", 32'(gs.state), 32'd0);
      chk("rst_game_reset", 32'(gs.game_reset), 32'd1);
      chk("rst_freeze", 32'(gs.freeze), 32'd1);
      chk("rst_blank", 32'(gs.blank), 32'd0);
      chk("rst_score", 32'(gs.score_bcd), 32'h000);
      chk("rst_hi", 32'(gs.hi_bcd), 32'h000);

      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         seen |= gs.scroll_en;
         tick;
      end
      chk("idle_state", 32'(gs.state), 32'd0);
      chk("idle_no_scroll", 32'(seen), 32'd0);
      chk("idle_game_reset", 32'(gs.game_reset), 32'd1);

      // Game 1: no-score scrolling, then speed-up, collision crash
      gs.start = 1'b1;
      tick;
      gs.start = 1'b0;
      chk("play_state", 32'(gs.state), 32'd1);
      chk("play_game_reset", 32'(gs.game_reset), 32'd0);
      chk("play_freeze", 32'(gs.freeze), 32'd0);
      for (int k = 1; k <= 40; k++) begin
         chk($sformatf("se_c%0d", k), 32'(gs.scroll_en),
             32'((k % 8) == 0));
         tick;
      end
      chk("noscore", 32'(gs.score_bcd), 32'h000);

      gs.green = 64'h81;
      play_points(1, 35);

      gs.start = 1'b1;
      chk("start_in_play", 32'(gs.state), 32'd1);
      tick;
      gs.start = 1'b0;
      chk("pre_collide_se", 32'(gs.scroll_en), 32'd1);
      gs.red = 64'h1;
      #1;
      chk("collide_se", 32'(gs.scroll_en), 32'd0);
      tick;
      gs.red = '0;
      chk("crash_state", 32'(gs.state), 32'd2);
      chk("crash_score", 32'(gs.score_bcd), 32'h035);
      chk("crash_hi", 32'(gs.hi_bcd), 32'h000);
      crash_flash(1'b1);
      chk("over_state", 32'(gs.state), 32'd3);
      chk("over_hi", 32'(gs.hi_bcd), 32'h035);
      chk("over_score", 32'(gs.score_bcd), 32'h035);
      chk("over_blank", 32'(gs.blank), 32'd0);
      chk("over_game_reset", 32'(gs.game_reset), 32'd0);
      gs.start = 1'b1;
      tick;
      gs.start = 1'b0;
      chk("back_idle", 32'(gs.state), 32'd0);
      chk("back_game_reset", 32'(gs.game_reset), 32'd1);

      // Game 2: lower score must not replace the high score
      gs.start = 1'b1;
      tick;
      gs.start = 1'b0;
      chk("g2_score_clr", 32'(gs.score_bcd), 32'h000);
      play_points(1, 3);
      gs.bird_lose = 1'b1;
      tick;
      gs.bird_lose = 1'b0;
      chk("g2_crash", 32'(gs.state), 32'd2);
      crash_flash(1'b0);
      chk("g2_over", 32'(gs.state), 32'd3);
      chk("g2_hi", 32'(gs.hi_bcd), 32'h035);
      chk("g2_score", 32'(gs.score_bcd), 32'h003);
      gs.start = 1'b1;
      tick;
      gs.start = 1'b0;

      // Game 3: BCD carries and saturation, then reset mid-crash
      gs.start = 1'b1;
      tick;
      gs.start = 1'b0;
      play_points(1, 1000);
      chk("sat_score", 32'(gs.score_bcd), 32'h999);
      gs.bird_lose = 1'b1;
      tick;
      gs.bird_lose = 1'b0;
      chk("g3_crash", 32'(gs.state), 32'd2);
      begin
         int k;
         k = 0;
         while (!gs.blank && k < 8) begin
            tick;
            k++;
         end
      end
      chk("g3_blank_on", 32'(gs.blank), 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("mid_rst_state", 32'(gs.state), 32'd0);
      chk("mid_rst_blank", 32'(gs.blank), 32'd0);
      chk("mid_rst_score", 32'(gs.score_bcd), 32'h000);
      chk("mid_rst_hi", 32'(gs.hi_bcd), 32'h000);
      chk("mid_rst_game_reset", 32'(gs.game_reset), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
